// File: rtl/fqc_pkg.sv
// Shared definitions for the factorial queue controller: register indices,
// STATUS/interrupt bit positions and the job FSM encoding.
package fqc_pkg;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_INTR_EN   = 3'd2;
  localparam logic [2:0] REG_INTR_STAT = 3'd3;
  localparam logic [2:0] REG_OPERAND   = 3'd4;
  localparam logic [2:0] REG_RESULT_H  = 3'd5;
  localparam logic [2:0] REG_RESULT_L  = 3'd6;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;

  localparam int ST_BUSY        = 0;
  localparam int ST_OP_FULL     = 1;
  localparam int ST_OP_EMPTY    = 2;
  localparam int ST_RES_EMPTY   = 3;
  localparam int ST_RES_FULL    = 4;
  localparam int ST_OP_CNT_LSB  = 8;
  localparam int ST_RES_CNT_LSB = 16;

  localparam int INTR_RESULT   = 0;
  localparam int INTR_OVERFLOW = 1;
  localparam int INTR_TIMEOUT  = 2;
  localparam int INTR_W        = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/factorial_queue_controller_fifo.sv
// Synchronous show-ahead FIFO with flush; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/factorial_queue_controller.sv
// Bus-mapped controller for the factorial core: queues operands, runs one job
// at a time under a watchdog, buffers results and raises maskable interrupts.
module factorial_queue_controller
  import fqc_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int OP_DEPTH  = 4,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [15:0]       s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              core_start,
  output logic              core_clear,
  output logic [DATA_W-1:0] core_operand,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_rh,
  input  logic [DATA_W-1:0] core_rl,
  output logic              irq
);

  localparam int OCW  = $clog2(OP_DEPTH) + 1;
  localparam int RCW  = $clog2(RES_DEPTH) + 1;
  localparam int WD_W = $clog2(TIMEOUT + 2);

  fsm_state_t        state;
  logic              enable;
  logic [INTR_W-1:0] intr_en;
  logic [INTR_W-1:0] intr_stat;
  logic [WD_W-1:0]   wd_cnt;

  logic [2:0]        reg_idx;
  logic              wr_en;
  logic              rd_en;
  logic              clear_req;
  logic              issue_go;
  logic              job_done;
  logic              wd_expire;
  logic              op_overflow;
  logic [INTR_W-1:0] hw_set;
  logic [INTR_W-1:0] w1c_mask;
  logic [DATA_W-1:0] rd_data;
  logic              unused_addr;

  logic              op_push, op_pop, op_full, op_empty;
  logic [DATA_W-1:0] op_head;
  logic [OCW-1:0]    op_count;

  logic                res_push, res_pop, res_full, res_empty;
  logic [2*DATA_W-1:0] res_head;
  logic [RCW-1:0]      res_count;

  assign reg_idx     = s_addr[5:3];
  assign unused_addr = ^{s_addr[15:6], s_addr[2:0]};
  assign wr_en       = s_sel && s_wr;
  assign rd_en       = s_sel && !s_wr;
  assign clear_req   = wr_en && (reg_idx == REG_CTRL) && s_din[CTRL_CLEAR];

  assign issue_go    = (state == S_IDLE) && enable && !op_empty && !res_full;
  assign op_pop      = (state == S_ISSUE);
  assign op_push     = wr_en && (reg_idx == REG_OPERAND);
  assign op_overflow = op_push && op_full && !op_pop;

  // A clear in the same cycle discards any result the core presents.
  assign job_done  = (state == S_WAIT) && core_done && !clear_req;
  assign wd_expire = (TIMEOUT != 0) && (state == S_WAIT) && !core_done &&
                     (wd_cnt >= WD_W'(TIMEOUT - 1));

  assign res_push = job_done;
  assign res_pop  = rd_en && (reg_idx == REG_RESULT_L) && !res_empty;

  assign irq = |(intr_stat & intr_en);

  always_comb begin
    hw_set                = '0;
    hw_set[INTR_RESULT]   = job_done;
    hw_set[INTR_OVERFLOW] = op_overflow;
    hw_set[INTR_TIMEOUT]  = wd_expire;
    w1c_mask = (wr_en && (reg_idx == REG_INTR_STAT)) ? s_din[INTR_W-1:0] : '0;
  end

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(OP_DEPTH)) u_op_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (op_push),
    .pop   (op_pop),
    .flush (clear_req),
    .din   (s_din),
    .head  (op_head),
    .count (op_count),
    .full  (op_full),
    .empty (op_empty)
  );

  sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (res_push),
    .pop   (res_pop),
    .flush (clear_req),
    .din   ({core_rh, core_rl}),
    .head  (res_head),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      enable       <= 1'b0;
      intr_en      <= '0;
      intr_stat    <= '0;
      wd_cnt       <= '0;
      core_start   <= 1'b0;
      core_clear   <= 1'b0;
      core_operand <= '0;
    end else begin
      core_start <= 1'b0;
      core_clear <= 1'b0;
      if (wr_en && (reg_idx == REG_CTRL))    enable  <= s_din[CTRL_ENABLE];
      if (wr_en && (reg_idx == REG_INTR_EN)) intr_en <= s_din[INTR_W-1:0];
      if (clear_req) begin
        state      <= S_IDLE;
        intr_stat  <= '0;
        core_clear <= 1'b1;
      end else begin
        // Hardware sets are ORed after the W1C mask so a coincident set wins.
        intr_stat <= (intr_stat & ~w1c_mask) | hw_set;
        case (state)
          S_IDLE: begin
            if (issue_go) begin
              state        <= S_ISSUE;
              core_start   <= 1'b1;
              core_operand <= op_head;
              wd_cnt       <= '0;
            end
          end
          S_ISSUE: begin
            state  <= S_WAIT;
            wd_cnt <= wd_cnt + 1'b1;
          end
          S_WAIT: begin
            if (job_done) begin
              state <= S_IDLE;
            end else if (wd_expire) begin
              state      <= S_IDLE;
              core_clear <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_CTRL:      rd_data[CTRL_ENABLE] = enable;
      REG_STATUS: begin
        rd_data[ST_BUSY]                   = (state != S_IDLE);
        rd_data[ST_OP_FULL]                = op_full;
        rd_data[ST_OP_EMPTY]               = op_empty;
        rd_data[ST_RES_EMPTY]              = res_empty;
        rd_data[ST_RES_FULL]               = res_full;
        rd_data[ST_OP_CNT_LSB +: OCW]      = op_count;
        rd_data[ST_RES_CNT_LSB +: RCW]     = res_count;
      end
      REG_INTR_EN:   rd_data[INTR_W-1:0] = intr_en;
      REG_INTR_STAT: rd_data[INTR_W-1:0] = intr_stat;
      REG_RESULT_H:  rd_data = res_empty ? '0 : res_head[2*DATA_W-1:DATA_W];
      REG_RESULT_L:  rd_data = res_empty ? '0 : res_head[DATA_W-1:0];
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      s_dout <= '0;
    else if (rd_en) s_dout <= rd_data;
  end

endmodule
